// File: rtl/booth_mul_seq_pkg.sv
// booth_pkg: shared FSM/digit types and radix-4 Booth triplet decode
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;
  localparam logic [2:0] T_Z0 = 3'b000;
  localparam logic [2:0] T_P1A = 3'b001;
  localparam logic [2:0] T_P1B = 3'b010;
  localparam logic [2:0] T_P2 = 3'b011;
  localparam logic [2:0] T_N2 = 3'b100;
  localparam logic [2:0] T_N1A = 3'b101;
  localparam logic [2:0] T_N1B = 3'b110;
  localparam logic [2:0] T_Z1 = 3'b111;
  function automatic digit_t decode(input logic [2:0] t);
    return (t == T_P1A || t == T_P1B) ? POS1 :
           (t == T_P2) ? POS2 :
           (t == T_N2) ? NEG2 :
           (t == T_N1A || t == T_N1B) ? NEG1 : ZERO;
  endfunction
endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: start/busy/done handshake with operands and HI/LO result
interface booth_mul_seq_if #(parameter int WIDTH = 32) ();
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, a, b, input busy, done, hi, lo);
  modport slave(input start, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/booth_mul_seq_recode.sv
// booth_recode: combinational Booth digit select producing a WIDTH+2-bit signed partial product
module booth_recode
  import booth_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic [2:0]       trip,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH+1:0] pp
);
  digit_t d;
  logic [WIDTH+1:0] ax;
  logic [WIDTH+1:0] ax2;
  always_comb begin
    d = decode(trip);
    ax = {{2{a[WIDTH-1]}}, a};
    ax2 = {ax[WIDTH:0], 1'b0};
    pp = d == POS1 ? ax : d == POS2 ? ax2 : d == NEG1 ? -ax : d == NEG2 ? -ax2 : '0;
  end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed radix-4 Booth multiplier, one digit per clock
module booth_mul_seq
  import booth_pkg::*;
#(parameter int WIDTH = 32) (
  input logic clk,
  input logic clr,
  booth_mul_seq_if.slave bus
);
  localparam int N = WIDTH / 2;
  localparam int CW = $clog2(N);
  state_t state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic prev;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH+1:0] pp;
  logic [2*WIDTH-1:0] sum;
  logic last;
  booth_recode #(.WIDTH(WIDTH)) u_recode (.trip({rb[1:0], prev}), .a(ra), .pp(pp));
  always_comb begin
    sum = acc + ({{(WIDTH-2){pp[WIDTH+1]}}, pp} << {cnt, 1'b0});
    last = cnt == CW'(N - 1);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
      acc <= '0;
      cnt <= '0;
      ra <= '0;
      rb <= '0;
      prev <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= bus.start ? RUN : IDLE;
          bus.busy <= bus.start;
          if (bus.start) begin
            ra <= bus.a;
            rb <= bus.b;
            acc <= '0;
            cnt <= '0;
            prev <= 1'b0;
          end
        end
        RUN: begin
          acc <= sum;
          rb <= rb >> 2;
          prev <= rb[1];
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            bus.hi <= sum[2*WIDTH-1:WIDTH];
            bus.lo <= sum[WIDTH-1:0];
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: randomized scoreboard bench against a 64-bit signed product model
module tb_booth_mul_seq;
  localparam int W = 32;
  logic clk = 0;
  logic clr = 1;
  int total = 0;
  int bad = 0;
  int ndone = 0;
  logic [2*W-1:0] expq[$];
  booth_mul_seq_if #(.WIDTH(W)) bus ();
  booth_mul_seq #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return sx * sy;
  endfunction

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!clr && bus.done) begin
      ndone++;
      chk("done_expected", 64'(expq.size() != 0), 64'd1);
      chk("busy_with_done", 64'(bus.busy), 64'd0);
      if (expq.size() != 0) chk("product", {bus.hi, bus.lo}, expq.pop_front());
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    bus.start = 1;
    bus.a = x;
    bus.b = y;
    expq.push_back(model(x, y));
    @(posedge clk);
    #1;
    bus.start = 0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  task automatic wait_done(output int busy_cyc);
    bit seen = 0;
    busy_cyc = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.busy) busy_cyc++;
    end
    chk("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input bit check_lat);
    int bc;
    issue(x, y);
    wait_done(bc);
    if (check_lat) begin
      chk("busy_cycles", 64'(bc), 64'd16);
      @(negedge clk);
      chk("done_pulse_width", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int bc, d0;
    logic [2*W-1:0] held;
    logic [W-1:0] corner[6];
    corner = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'hAAAA_AAAA};
    bus.start = 0;
    bus.a = 0;
    bus.b = 0;
    repeat (2) @(posedge clk);
    #1 clr = 0;
    @(negedge clk);
    chk("reset_state", {60'd0, bus.busy, bus.done, |bus.hi, |bus.lo}, 64'd0);
    run(32'd7, 32'hFFFF_FFFD, 1);
    run(32'h8000_0000, 32'h8000_0000, 1);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run(32'h0, 32'h1234_5678, 1);
    held = {bus.hi, bus.lo};
    d0 = ndone;
    issue(32'd5, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1;
    bus.a = 9;
    bus.b = 9;
    repeat (3) @(posedge clk);
    #1 bus.start = 0;
    @(negedge clk);
    chk("hold_before_done", {bus.hi, bus.lo}, held);
    wait_done(bc);
    repeat (20) @(negedge clk);
    chk("single_done", 64'(ndone - d0), 64'd1);
    d0 = ndone;
    @(posedge clk);
    #1;
    bus.start = 1;
    bus.a = 7;
    bus.b = 32'hFFFF_FFFD;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (8) @(posedge clk);
    #1 clr = 1;
    @(posedge clk);
    #1 clr = 0;
    @(negedge clk);
    chk("abort_state", {60'd0, bus.busy, bus.done, |bus.hi, |bus.lo}, 64'd0);
    repeat (25) @(negedge clk);
    chk("no_done_after_abort", 64'(ndone - d0), 64'd0);
    run(32'd3, 32'd4, 1);
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(bc);
    #1;
    bus.start = 1;
    bus.a = 2;
    bus.b = 3;
    expq.push_back(model(32'd2, 32'd3));
    @(posedge clk);
    #1 bus.start = 0;
    bc = 1;
    @(negedge clk);
    chk("b2b_busy_after_done", {62'd0, bus.busy, bus.done}, 64'd2);
    for (int k = 0; k < 40 && !bus.done; k++) begin
      @(negedge clk);
      bc++;
    end
    chk("b2b_spacing", 64'(bc), 64'd17);
    @(negedge clk);
    chk("b2b_pulse_width", 64'(bus.done), 64'd0);
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      run(x, y, k < 20);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
